itch_book_builder: RTL and testbench
====================================

// Module: itch_book_builder
// PURPOSE
// Consumes decoded ITCH order events from the ITCH parser and keeps a price-level
// aggregated limit order book for one instrument (stock locate). Each side holds DEPTH
// sorted levels. The block publishes the best bid and best ask to the downstream
// strategy logic. There is no backpressure: one event can be accepted on every cycle.
// PARAMETERS
// LOCATE  16'h0001  stock locate tracked; events with any other locate are ignored
// DEPTH   8         price levels kept per side (2..16)
// PORTS
// clkIn             in   1   system clock
// rstIn             in   1   synchronous active-high reset
// msgValidIn        in   1   event strobe, one cycle per event
// msgTypeIn         in   2   00 ADD, 01 EXECUTE, 10 CANCEL, 11 DELETE
// locateIn          in   16  stock locate of the event
// buySellIn         in   1   1 = bid side, 0 = ask side
// sharesIn          in   32  share quantity (unsigned)
// priceIn           in   32  price, 4 implied decimals (unsigned)
// clearIn           in   1   empties both sides (asserted on packet loss)
// bidValidOut       out  1   bid side holds at least one level
// bidPriceOut       out  32  best (highest) bid price
// bidSharesOut      out  32  aggregate shares at the best bid
// askValidOut       out  1   ask side holds at least one level
// askPriceOut       out  32  best (lowest) ask price
// askSharesOut      out  32  aggregate shares at the best ask
// topUpdateOut      out  1   one-cycle pulse when any top-of-book output changed
// dropOut           out  1   one-cycle pulse: a level was discarded because a side was full
// missOut           out  1   one-cycle pulse: decrement hit an absent price, or underflowed
// BEHAVIOUR
// - Reset: both sides empty. Every output is 0.
// - Each side is a register array of {price, shares, valid}. Entry 0 is the best level.
//   Valid entries are contiguous from entry 0.
// - Sort order: bids descend by price, asks ascend. No two valid entries share a price.
// - Accept condition: msgValidIn && locateIn==LOCATE && !clearIn. Only the buySellIn side changes.
// - Timing: the array updates on the edge after acceptance. The top-of-book outputs and
//   the pulses are registered one cycle later, so latency is 2 cycles.
// - Back-to-back events: each event sees the array state produced by the previous event.
//   The compare and the update happen in the same cycle, so no hazard is possible.
// - ADD, price present: shares = shares + sharesIn, saturating at 32'hFFFF_FFFF.
// - ADD, price absent: insert at its sorted position and shift worse levels down by one.
// - ADD, side full, new price better than the worst level: the worst level falls off the end. Pulse dropOut.
// - ADD, side full, new price equal to or worse than the worst level: the event is discarded. Pulse dropOut.
// - EXECUTE/CANCEL/DELETE: subtract sharesIn from the matching level.
// - Result 0: remove the level and shift worse levels up by one.
// - Underflow (sharesIn > level shares): remove the level and pulse missOut.
// - Decrement with no matching price: no change. Pulse missOut.
// - clearIn: every valid bit goes to 0 on the next edge. Takes priority over an event in the same cycle.
// - clearIn with msgValidIn in the same cycle: the event is dropped with no pulse.
// - topUpdateOut compares the registered top-of-book against its previous value.
// - A change deeper in the book does not assert topUpdateOut.
// - An empty side drives its Price and Shares outputs to 0.
// - rstIn asserted mid-stream: the book is emptied on that edge. Any event in the same cycle is lost.
// TESTING
// - ADD bid 100@1_000_000, then ADD bid 50@1_010_000 -> after 2 cycles bid=1_010_000/50,
//   bidValid=1, topUpdate pulses once per event.
// - ADD ask 200@1_020_000, then CANCEL ask 200@1_020_000 -> askValid returns to 0 and askPrice to 0.
// - Fill the bid side with 8 prices 1..8. ADD bid @9 -> price 1 evicted, dropOut=1, top=9.
//   ADD bid @0 -> book unchanged, dropOut=1.
// - EXECUTE bid 10@777 with 777 absent -> missOut=1, no topUpdate.
//   EXECUTE 150 against a level of 100 -> level removed, missOut=1.
// - Back-to-back for 3 cycles: ADD ask 10@500, ADD ask 5@500, DELETE ask 15@500 -> ask side empty.
//   topUpdate pulses on cycles 1, 2 and 3.
// - Event with locate=2 -> ignored. clearIn in the same cycle as an ADD -> book empty, no pulses.

Source files
------------

// File: rtl/itch_book_builder.sv
// Price-level aggregated order book for one stock locate: DEPTH sorted levels per side,
// best bid/ask published two cycles after an event is accepted.
module itch_book_builder #(
  parameter logic [15:0] LOCATE = 16'h0001,
  parameter int          DEPTH  = 8
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        msgValidIn,
  input  logic [1:0]  msgTypeIn,
  input  logic [15:0] locateIn,
  input  logic        buySellIn,
  input  logic [31:0] sharesIn,
  input  logic [31:0] priceIn,
  input  logic        clearIn,
  output logic        bidValidOut,
  output logic [31:0] bidPriceOut,
  output logic [31:0] bidSharesOut,
  output logic        askValidOut,
  output logic [31:0] askPriceOut,
  output logic [31:0] askSharesOut,
  output logic        topUpdateOut,
  output logic        dropOut,
  output logic        missOut
);

  localparam logic [1:0] MSG_ADD = 2'b00;

  logic [31:0]      bid_px_q [DEPTH];
  logic [31:0]      bid_px_d [DEPTH];
  logic [31:0]      bid_sh_q [DEPTH];
  logic [31:0]      bid_sh_d [DEPTH];
  logic [DEPTH-1:0] bid_v_q, bid_v_d;
  logic [31:0]      ask_px_q [DEPTH];
  logic [31:0]      ask_px_d [DEPTH];
  logic [31:0]      ask_sh_q [DEPTH];
  logic [31:0]      ask_sh_d [DEPTH];
  logic [DEPTH-1:0] ask_v_q, ask_v_d;

  logic [31:0]      cur_px [DEPTH];
  logic [31:0]      cur_sh [DEPTH];
  logic [DEPTH-1:0] cur_v;
  logic [31:0]      new_px [DEPTH];
  logic [31:0]      new_sh [DEPTH];
  logic [DEPTH-1:0] new_v;

  logic        accept;
  logic        hit;
  logic [31:0] hit_sh;
  logic [32:0] add_sum;
  int          pos;
  logic        drop_evt_d, drop_evt_q;
  logic        miss_evt_d, miss_evt_q;

  logic        bid_out_v_q, ask_out_v_q;
  logic [31:0] bid_out_px_q, bid_out_sh_q, ask_out_px_q, ask_out_sh_q;
  logic        bid_out_v_d, ask_out_v_d;
  logic [31:0] bid_out_px_d, bid_out_sh_d, ask_out_px_d, ask_out_sh_d;
  logic        top_upd_q, top_upd_d;
  logic        drop_q, miss_q;

  assign accept = msgValidIn && (locateIn == LOCATE) && !clearIn;

  // Only the addressed side is evaluated; pos counts strictly better levels, so it is both
  // the insertion slot for a new price and the index of a matching level.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cur_px[i] = buySellIn ? bid_px_q[i] : ask_px_q[i];
      cur_sh[i] = buySellIn ? bid_sh_q[i] : ask_sh_q[i];
    end
    cur_v  = buySellIn ? bid_v_q : ask_v_q;
    new_px = cur_px;
    new_sh = cur_sh;
    new_v  = cur_v;
    hit    = 1'b0;
    hit_sh = '0;
    pos    = 0;
    drop_evt_d = 1'b0;
    miss_evt_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cur_v[i] && cur_px[i] == priceIn) begin
        hit    = 1'b1;
        hit_sh = cur_sh[i];
      end
      if (cur_v[i] && (buySellIn ? (cur_px[i] > priceIn) : (cur_px[i] < priceIn)))
        pos = pos + 1;
    end
    add_sum = {1'b0, hit_sh} + {1'b0, sharesIn};

    if (msgTypeIn == MSG_ADD) begin
      if (hit) begin
        for (int i = 0; i < DEPTH; i++)
          if (i == pos) new_sh[i] = add_sum[32] ? 32'hFFFF_FFFF : add_sum[31:0];
      end else if (cur_v[DEPTH-1] && pos == DEPTH) begin
        drop_evt_d = accept;
      end else begin
        drop_evt_d = accept && cur_v[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) begin
          if (i > pos) begin
            new_px[i] = cur_px[i-1];
            new_sh[i] = cur_sh[i-1];
            new_v[i]  = cur_v[i-1];
          end
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (i == pos) begin
            new_px[i] = priceIn;
            new_sh[i] = sharesIn;
            new_v[i]  = 1'b1;
          end
        end
      end
    end else begin
      if (!hit) begin
        miss_evt_d = accept;
      end else if (sharesIn >= hit_sh) begin
        miss_evt_d = accept && (sharesIn > hit_sh);
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (i >= pos) begin
            new_px[i] = cur_px[i+1];
            new_sh[i] = cur_sh[i+1];
            new_v[i]  = cur_v[i+1];
          end
        end
        new_v[DEPTH-1] = 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++)
          if (i == pos) new_sh[i] = hit_sh - sharesIn;
      end
    end
  end

  always_comb begin
    bid_px_d = bid_px_q;
    bid_sh_d = bid_sh_q;
    bid_v_d  = bid_v_q;
    ask_px_d = ask_px_q;
    ask_sh_d = ask_sh_q;
    ask_v_d  = ask_v_q;
    if (clearIn) begin
      bid_v_d = '0;
      ask_v_d = '0;
    end else if (accept && buySellIn) begin
      bid_px_d = new_px;
      bid_sh_d = new_sh;
      bid_v_d  = new_v;
    end else if (accept) begin
      ask_px_d = new_px;
      ask_sh_d = new_sh;
      ask_v_d  = new_v;
    end
  end

  // Empty sides publish zero price/shares regardless of stale array contents.
  always_comb begin
    bid_out_v_d  = bid_v_q[0];
    bid_out_px_d = bid_v_q[0] ? bid_px_q[0] : 32'd0;
    bid_out_sh_d = bid_v_q[0] ? bid_sh_q[0] : 32'd0;
    ask_out_v_d  = ask_v_q[0];
    ask_out_px_d = ask_v_q[0] ? ask_px_q[0] : 32'd0;
    ask_out_sh_d = ask_v_q[0] ? ask_sh_q[0] : 32'd0;
    top_upd_d = (bid_out_v_d != bid_out_v_q) || (bid_out_px_d != bid_out_px_q) ||
                (bid_out_sh_d != bid_out_sh_q) || (ask_out_v_d != ask_out_v_q) ||
                (ask_out_px_d != ask_out_px_q) || (ask_out_sh_d != ask_out_sh_q);
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      for (int i = 0; i < DEPTH; i++) begin
        bid_px_q[i] <= '0;
        bid_sh_q[i] <= '0;
        ask_px_q[i] <= '0;
        ask_sh_q[i] <= '0;
      end
      bid_v_q      <= '0;
      ask_v_q      <= '0;
      drop_evt_q   <= 1'b0;
      miss_evt_q   <= 1'b0;
      bid_out_v_q  <= 1'b0;
      bid_out_px_q <= '0;
      bid_out_sh_q <= '0;
      ask_out_v_q  <= 1'b0;
      ask_out_px_q <= '0;
      ask_out_sh_q <= '0;
      top_upd_q    <= 1'b0;
      drop_q       <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      bid_px_q     <= bid_px_d;
      bid_sh_q     <= bid_sh_d;
      bid_v_q      <= bid_v_d;
      ask_px_q     <= ask_px_d;
      ask_sh_q     <= ask_sh_d;
      ask_v_q      <= ask_v_d;
      drop_evt_q   <= drop_evt_d;
      miss_evt_q   <= miss_evt_d;
      bid_out_v_q  <= bid_out_v_d;
      bid_out_px_q <= bid_out_px_d;
      bid_out_sh_q <= bid_out_sh_d;
      ask_out_v_q  <= ask_out_v_d;
      ask_out_px_q <= ask_out_px_d;
      ask_out_sh_q <= ask_out_sh_d;
      top_upd_q    <= top_upd_d;
      drop_q       <= drop_evt_q;
      miss_q       <= miss_evt_q;
    end
  end

  assign bidValidOut  = bid_out_v_q;
  assign bidPriceOut  = bid_out_px_q;
  assign bidSharesOut = bid_out_sh_q;
  assign askValidOut  = ask_out_v_q;
  assign askPriceOut  = ask_out_px_q;
  assign askSharesOut = ask_out_sh_q;
  assign topUpdateOut = top_upd_q;
  assign dropOut      = drop_q;
  assign missOut      = miss_q;

endmodule

// File: tb/tb_itch_book_builder.sv
// Bench for itch_book_builder: directed scenarios plus random events against a
// queue-based book model with a two-cycle output pipeline.
module tb_itch_book_builder;
  localparam int DEPTH = 8;
  localparam logic [1:0] ADD = 2'b00, EXE = 2'b01, CAN = 2'b10, DEL = 2'b11;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b0;
  logic        msgValidIn = 1'b0;
  logic [1:0]  msgTypeIn = '0;
  logic [15:0] locateIn = '0;
  logic        buySellIn = 1'b0;
  logic [31:0] sharesIn = '0;
  logic [31:0] priceIn = '0;
  logic        clearIn = 1'b0;
  logic        bidValidOut, askValidOut, topUpdateOut, dropOut, missOut;
  logic [31:0] bidPriceOut, bidSharesOut, askPriceOut, askSharesOut;

  int checks = 0;
  int failures = 0;

  itch_book_builder dut (
    .clkIn(clkIn), .rstIn(rstIn), .msgValidIn(msgValidIn), .msgTypeIn(msgTypeIn),
    .locateIn(locateIn), .buySellIn(buySellIn), .sharesIn(sharesIn), .priceIn(priceIn),
    .clearIn(clearIn), .bidValidOut(bidValidOut), .bidPriceOut(bidPriceOut),
    .bidSharesOut(bidSharesOut), .askValidOut(askValidOut), .askPriceOut(askPriceOut),
    .askSharesOut(askSharesOut), .topUpdateOut(topUpdateOut), .dropOut(dropOut),
    .missOut(missOut)
  );

  always #5 clkIn = ~clkIn;

  // Reference book: index 0 is the best level on each side.
  logic [31:0] m_bid_px[$], m_bid_sh[$], m_ask_px[$], m_ask_sh[$];

  typedef struct packed {
    logic        bv;
    logic [31:0] bp;
    logic [31:0] bs;
    logic        av;
    logic [31:0] ap;
    logic [31:0] as_;
  } top_t;

  top_t s1_top, ex_top;
  logic s1_drop, s1_miss, ex_drop, ex_miss, ex_tu;

  task automatic model_apply(input logic [1:0] t, input logic bs, input logic [31:0] sh,
                             input logic [31:0] px, output logic drop, output logic miss);
    logic [31:0] pq[$], sq[$];
    logic [32:0] sum;
    int idx, k;
    drop = 1'b0;
    miss = 1'b0;
    if (bs) begin pq = m_bid_px; sq = m_bid_sh; end
    else    begin pq = m_ask_px; sq = m_ask_sh; end
    idx = -1;
    for (int i = 0; i < pq.size(); i++) if (pq[i] == px) idx = i;
    if (t == ADD) begin
      if (idx >= 0) begin
        sum = {1'b0, sq[idx]} + {1'b0, sh};
        sq[idx] = (sum > 33'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
      end else begin
        k = pq.size();
        for (int i = pq.size() - 1; i >= 0; i--)
          if (bs ? (px > pq[i]) : (px < pq[i])) k = i;
        if (pq.size() == DEPTH && k == DEPTH) drop = 1'b1;
        else begin
          pq.insert(k, px);
          sq.insert(k, sh);
          if (pq.size() > DEPTH) begin
            void'(pq.pop_back());
            void'(sq.pop_back());
            drop = 1'b1;
          end
        end
      end
    end else if (idx < 0) begin
      miss = 1'b1;
    end else if (sh >= sq[idx]) begin
      miss = (sh > sq[idx]);
      pq.delete(idx);
      sq.delete(idx);
    end else begin
      sq[idx] = sq[idx] - sh;
    end
    if (bs) begin m_bid_px = pq; m_bid_sh = sq; end
    else    begin m_ask_px = pq; m_ask_sh = sq; end
  endtask

  function automatic top_t model_top();
    top_t r;
    r.bv  = (m_bid_px.size() > 0);
    r.bp  = r.bv ? m_bid_px[0] : 32'd0;
    r.bs  = r.bv ? m_bid_sh[0] : 32'd0;
    r.av  = (m_ask_px.size() > 0);
    r.ap  = r.av ? m_ask_px[0] : 32'd0;
    r.as_ = r.av ? m_ask_sh[0] : 32'd0;
    return r;
  endfunction

  // Drives one cycle; afterwards ex_* describes what the outputs must show now.
  task automatic step(input logic v, input logic [1:0] t, input logic [15:0] loc, input logic bs,
                      input logic [31:0] sh, input logic [31:0] px, input logic clr);
    logic d, m;
    top_t n;
    msgValidIn = v; msgTypeIn = t; locateIn = loc; buySellIn = bs;
    sharesIn = sh; priceIn = px; clearIn = clr;
    d = 1'b0;
    m = 1'b0;
    if (clr) begin
      m_bid_px.delete(); m_bid_sh.delete(); m_ask_px.delete(); m_ask_sh.delete();
    end else if (v && loc == 16'h0001) begin
      model_apply(t, bs, sh, px, d, m);
    end
    n = model_top();
    @(posedge clkIn);
    #1;
    msgValidIn = 1'b0;
    clearIn = 1'b0;
    ex_tu   = (s1_top != ex_top);
    ex_top  = s1_top;
    ex_drop = s1_drop;
    ex_miss = s1_miss;
    s1_top  = n;
    s1_drop = d;
    s1_miss = m;
  endtask

  task automatic idle();
    step(1'b0, ADD, 16'h0001, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    rstIn = 1'b1;
    @(posedge clkIn); #1;
    msgValidIn = 1'b0;
    @(posedge clkIn); #1;
    rstIn = 1'b0;
    m_bid_px.delete(); m_bid_sh.delete(); m_ask_px.delete(); m_ask_sh.delete();
    s1_top = '0; ex_top = '0;
    s1_drop = 1'b0; s1_miss = 1'b0; ex_drop = 1'b0; ex_miss = 1'b0; ex_tu = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bidValidOut, bidPriceOut, bidSharesOut, askValidOut, askPriceOut, askSharesOut,
         topUpdateOut, dropOut, missOut} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got bv=%0b bp=%0d bs=%0d av=%0b ap=%0d as=%0d tu=%0b d=%0b m=%0b, want all 0",
               bidValidOut, bidPriceOut, bidSharesOut, askValidOut, askPriceOut, askSharesOut,
               topUpdateOut, dropOut, missOut);
    end
  endtask

  task automatic test_add_bid();
    do_reset();
    step(1, ADD, 16'h0001, 1, 32'd100, 32'd1_000_000, 0);
    step(1, ADD, 16'h0001, 1, 32'd50, 32'd1_010_000, 0);
    checks++;
    if ({bidValidOut, bidPriceOut, bidSharesOut, topUpdateOut} !== {1'b1, 32'd1_000_000, 32'd100, 1'b1}) begin
      failures++;
      $display("FAIL add_bid_first: got v=%0b px=%0d sh=%0d tu=%0b, want 1/1000000/100/1",
               bidValidOut, bidPriceOut, bidSharesOut, topUpdateOut);
    end
    idle();
    checks++;
    if ({bidValidOut, bidPriceOut, bidSharesOut, topUpdateOut} !== {1'b1, 32'd1_010_000, 32'd50, 1'b1}) begin
      failures++;
      $display("FAIL add_bid_better: got v=%0b px=%0d sh=%0d tu=%0b, want 1/1010000/50/1",
               bidValidOut, bidPriceOut, bidSharesOut, topUpdateOut);
    end
    idle();
    checks++;
    if (topUpdateOut !== 1'b0) begin
      failures++;
      $display("FAIL add_bid_quiet: got tu=%0b, want 0", topUpdateOut);
    end
  endtask

  task automatic test_cancel_ask();
    do_reset();
    step(1, ADD, 16'h0001, 0, 32'd200, 32'd1_020_000, 0);
    step(1, CAN, 16'h0001, 0, 32'd200, 32'd1_020_000, 0);
    checks++;
    if ({askValidOut, askPriceOut, askSharesOut} !== {1'b1, 32'd1_020_000, 32'd200}) begin
      failures++;
      $display("FAIL cancel_ask_added: got v=%0b px=%0d sh=%0d, want 1/1020000/200",
               askValidOut, askPriceOut, askSharesOut);
    end
    idle();
    checks++;
    if ({askValidOut, askPriceOut, askSharesOut, topUpdateOut, missOut} !== {1'b0, 64'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL cancel_ask_empty: got v=%0b px=%0d sh=%0d tu=%0b m=%0b, want 0/0/0/1/0",
               askValidOut, askPriceOut, askSharesOut, topUpdateOut, missOut);
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int p = 1; p <= 8; p++) step(1, ADD, 16'h0001, 1, 32'd10, p, 0);
    idle();
    idle();
    checks++;
    if ({bidPriceOut, dropOut} !== {32'd8, 1'b0}) begin
      failures++;
      $display("FAIL full_fill: got px=%0d d=%0b, want 8/0", bidPriceOut, dropOut);
    end
    step(1, ADD, 16'h0001, 1, 32'd10, 32'd9, 0);
    idle();
    checks++;
    if ({bidPriceOut, dropOut, topUpdateOut} !== {32'd9, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL full_evict: got px=%0d d=%0b tu=%0b, want 9/1/1", bidPriceOut, dropOut, topUpdateOut);
    end
    step(1, ADD, 16'h0001, 1, 32'd10, 32'd0, 0);
    idle();
    checks++;
    if ({bidPriceOut, dropOut, topUpdateOut} !== {32'd9, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL full_discard: got px=%0d d=%0b tu=%0b, want 9/1/0", bidPriceOut, dropOut, topUpdateOut);
    end
    for (int p = 9; p >= 2; p--) step(1, DEL, 16'h0001, 1, 32'd10, p, 0);
    idle();
    idle();
    checks++;
    if ({bidValidOut, missOut} !== 2'b00) begin
      failures++;
      $display("FAIL full_drain: got v=%0b m=%0b, want 0/0 (levels 1 and 0 must be gone)", bidValidOut, missOut);
    end
  endtask

  task automatic test_miss();
    do_reset();
    step(1, ADD, 16'h0001, 1, 32'd100, 32'd2000, 0);
    idle();
    step(1, EXE, 16'h0001, 1, 32'd10, 32'd777, 0);
    idle();
    checks++;
    if ({missOut, topUpdateOut, bidPriceOut, bidSharesOut} !== {1'b1, 1'b0, 32'd2000, 32'd100}) begin
      failures++;
      $display("FAIL miss_absent: got m=%0b tu=%0b px=%0d sh=%0d, want 1/0/2000/100",
               missOut, topUpdateOut, bidPriceOut, bidSharesOut);
    end
    step(1, EXE, 16'h0001, 1, 32'd150, 32'd2000, 0);
    idle();
    checks++;
    if ({missOut, topUpdateOut, bidValidOut} !== {1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL miss_underflow: got m=%0b tu=%0b v=%0b, want 1/1/0", missOut, topUpdateOut, bidValidOut);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, ADD, 16'h0001, 0, 32'd10, 32'd500, 0);
    step(1, ADD, 16'h0001, 0, 32'd5, 32'd500, 0);
    checks++;
    if ({topUpdateOut, askPriceOut, askSharesOut} !== {1'b1, 32'd500, 32'd10}) begin
      failures++;
      $display("FAIL b2b_c1: got tu=%0b px=%0d sh=%0d, want 1/500/10", topUpdateOut, askPriceOut, askSharesOut);
    end
    step(1, DEL, 16'h0001, 0, 32'd15, 32'd500, 0);
    checks++;
    if ({topUpdateOut, askPriceOut, askSharesOut} !== {1'b1, 32'd500, 32'd15}) begin
      failures++;
      $display("FAIL b2b_c2: got tu=%0b px=%0d sh=%0d, want 1/500/15", topUpdateOut, askPriceOut, askSharesOut);
    end
    idle();
    checks++;
    if ({topUpdateOut, askValidOut, askPriceOut, missOut} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_c3: got tu=%0b v=%0b px=%0d m=%0b, want 1/0/0/0", topUpdateOut, askValidOut, askPriceOut, missOut);
    end
  endtask

  task automatic test_locate_clear();
    do_reset();
    step(1, ADD, 16'h0002, 1, 32'd10, 32'd300, 0);
    idle();
    checks++;
    if ({bidValidOut, topUpdateOut} !== 2'b00) begin
      failures++;
      $display("FAIL locate_ignored: got v=%0b tu=%0b, want 0/0", bidValidOut, topUpdateOut);
    end
    step(1, ADD, 16'h0001, 0, 32'd5, 32'd400, 1);
    idle();
    checks++;
    if ({askValidOut, topUpdateOut, dropOut, missOut} !== 4'b0000) begin
      failures++;
      $display("FAIL clear_with_add: got v=%0b tu=%0b d=%0b m=%0b, want 0/0/0/0",
               askValidOut, topUpdateOut, dropOut, missOut);
    end
    step(1, ADD, 16'h0001, 1, 32'd10, 32'd300, 0);
    idle();
    step(0, ADD, 16'h0001, 0, 32'd0, 32'd0, 1);
    idle();
    checks++;
    if ({bidValidOut, bidPriceOut, topUpdateOut} !== {1'b0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL clear_book: got v=%0b px=%0d tu=%0b, want 0/0/1", bidValidOut, bidPriceOut, topUpdateOut);
    end
  endtask

  task automatic test_random();
    logic v, bs, clr;
    logic [1:0] t;
    logic [15:0] loc;
    logic [31:0] sh, px;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom_range(7) != 0);
      t   = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : ADD;
      loc = ($urandom_range(15) == 0) ? 16'h0002 : 16'h0001;
      bs  = 1'($urandom_range(1));
      px  = 32'd100 + 32'($urandom_range(13));
      sh  = ($urandom_range(31) == 0) ? 32'hFFFF_FFF0 : 32'($urandom_range(200, 1));
      clr = ($urandom_range(63) == 0);
      step(v, t, loc, bs, sh, px, clr);
      checks++;
      if ({bidValidOut, bidPriceOut, bidSharesOut, askValidOut, askPriceOut, askSharesOut,
           topUpdateOut, dropOut, missOut} !==
          {ex_top.bv, ex_top.bp, ex_top.bs, ex_top.av, ex_top.ap, ex_top.as_, ex_tu, ex_drop, ex_miss}) begin
        failures++;
        $display("FAIL random_step%0d: got bid %0b/%0d/%0d ask %0b/%0d/%0d tu=%0b d=%0b m=%0b, want bid %0b/%0d/%0d ask %0b/%0d/%0d tu=%0b d=%0b m=%0b",
                 n, bidValidOut, bidPriceOut, bidSharesOut, askValidOut, askPriceOut, askSharesOut,
                 topUpdateOut, dropOut, missOut, ex_top.bv, ex_top.bp, ex_top.bs, ex_top.av,
                 ex_top.ap, ex_top.as_, ex_tu, ex_drop, ex_miss);
      end
    end
  endtask

  task automatic test_reset_midstream();
    step(1, ADD, 16'h0001, 1, 32'd10, 32'd5000, 0);
    step(1, ADD, 16'h0001, 0, 32'd10, 32'd6000, 0);
    msgValidIn = 1'b1; msgTypeIn = ADD; locateIn = 16'h0001; buySellIn = 1'b1;
    sharesIn = 32'd7; priceIn = 32'd7000;
    do_reset();
    idle();
    idle();
    checks++;
    if ({bidValidOut, askValidOut, bidPriceOut, topUpdateOut} !== {2'b00, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_midstream: got bv=%0b av=%0b bp=%0d tu=%0b, want 0/0/0/0",
               bidValidOut, askValidOut, bidPriceOut, topUpdateOut);
    end
  endtask

  initial begin
    test_reset();
    test_add_bid();
    test_cancel_ask();
    test_full_drop();
    test_miss();
    test_back_to_back();
    test_locate_clear();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
